mem_sched: RTL

MEM_SCHED -- requirements
Module: mem_sched

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_sched_rr2.sv | 21 ++
 rtl/mem_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory request scheduler.
package mem_pkg;

  localparam int unsigned PA_WIDTH_DEFAULT   = 32;
  localparam int unsigned LINE_WIDTH_DEFAULT = 128;
  localparam int unsigned ID_WIDTH_DEFAULT   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } src_t;

  // Request record at the default widths; mem_sched keeps a parameter-sized
  // copy with the same field layout.
  typedef struct packed {
    logic [PA_WIDTH_DEFAULT-1:0]   addr;
    logic [LINE_WIDTH_DEFAULT-1:0] data;
    logic                          write;
    src_t                          src;
  } mem_req_t;

endpackage

// File: rtl/mem_sched_rr2.sv
// Two-way fairness picker: on contention the side not granted last time wins.
module rr2
  import mem_pkg::*;
(
  input  logic req_instr,
  input  logic req_data,
  input  src_t last_grant,
  output src_t winner
);

  // Choose the winner from the pending requests and the previous grant.
  always_comb begin
    winner = INSTR;
    if (req_instr && req_data) begin
      winner = (last_grant == DATA) ? INSTR : DATA;
    end else if (req_data) begin
      winner = DATA;
    end
  end

endmodule

// File: rtl/mem_sched.sv
// Single-outstanding memory scheduler shared by the I-cache and D-cache.
module mem_sched
  import mem_pkg::*;
#(
  parameter int unsigned PA_WIDTH   = PA_WIDTH_DEFAULT,
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEFAULT,
  parameter int unsigned ID_WIDTH   = ID_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_instr_enable,
  input  logic [PA_WIDTH-1:0]   i_instr_addr,
  input  logic                  i_data_enable,
  input  logic [PA_WIDTH-1:0]   i_data_addr,
  input  logic [LINE_WIDTH-1:0] i_data,
  input  logic                  i_data_write,
  output logic                  o_instr_grant,
  output logic                  o_data_grant,
  output logic [ID_WIDTH-1:0]   o_mem_id,
  output logic                  o_mem_enable,
  output logic [PA_WIDTH-1:0]   o_mem_addr,
  output logic [LINE_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_write,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_valid,
  input  logic [LINE_WIDTH-1:0] i_mem_rdata,
  output logic                  o_resp_enable,
  output logic [LINE_WIDTH-1:0] o_resp_data,
  output logic [ID_WIDTH-1:0]   o_resp_id,
  output logic                  o_busy
);

  typedef struct packed {
    logic [PA_WIDTH-1:0]   addr;
    logic [LINE_WIDTH-1:0] data;
    logic                  write;
    src_t                  src;
  } req_t;

  state_t                state, state_next;
  req_t                  req_q, req_sel;
  src_t                  last_grant, winner;
  logic [ID_WIDTH-1:0]   id_cnt, cur_id;
  logic [LINE_WIDTH-1:0] resp_data_q;
  logic                  grant_instr_q, grant_data_q;
  logic                  any_req, take;

  rr2 u_rr2 (
    .req_instr  (i_instr_enable),
    .req_data   (i_data_enable),
    .last_grant (last_grant),
    .winner     (winner)
  );

  assign any_req = i_instr_enable | i_data_enable;
  assign take    = (state == IDLE) && any_req;

  // Assemble the winning requester's command for latching on the grant edge.
  always_comb begin
    req_sel = '0;
    if (winner == DATA) begin
      req_sel.addr  = i_data_addr;
      req_sel.data  = i_data;
      req_sel.write = i_data_write;
      req_sel.src   = DATA;
    end else begin
      req_sel.addr  = i_instr_addr;
      req_sel.src   = INSTR;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; ready and valid only matter in their own states.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req)     state_next = ISSUE;
      ISSUE:   if (i_mem_ready) state_next = req_q.write ? RESP : WAIT;
      WAIT:    if (i_mem_valid) state_next = RESP;
      RESP:                     state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Transaction latch, ID allocation, fairness history and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q         <= '0;
      cur_id        <= '0;
      id_cnt        <= '0;
      last_grant    <= INSTR;
      resp_data_q   <= '0;
      grant_instr_q <= 1'b0;
      grant_data_q  <= 1'b0;
    end else begin
      grant_instr_q <= take && (winner == INSTR);
      grant_data_q  <= take && (winner == DATA);
      if (take) begin
        req_q      <= req_sel;
        cur_id     <= id_cnt;
        id_cnt     <= id_cnt + 1'b1;
        last_grant <= winner;
      end
      if ((state == ISSUE) && i_mem_ready && req_q.write) begin
        resp_data_q <= '0;
      end
      if ((state == WAIT) && i_mem_valid) begin
        resp_data_q <= i_mem_rdata;
      end
    end
  end

  // Drive the memory command and completion broadcast from the current state.
  always_comb begin
    o_instr_grant = grant_instr_q;
    o_data_grant  = grant_data_q;
    o_mem_id      = cur_id;
    o_mem_enable  = 1'b0;
    o_mem_addr    = '0;
    o_mem_data    = '0;
    o_mem_write   = 1'b0;
    o_resp_enable = 1'b0;
    o_resp_data   = '0;
    o_resp_id     = '0;
    o_busy        = (state != IDLE);
    if (state == ISSUE) begin
      o_mem_enable = 1'b1;
      o_mem_addr   = req_q.addr;
      o_mem_data   = req_q.data;
      o_mem_write  = req_q.write;
    end
    if (state == RESP) begin
      o_resp_enable = 1'b1;
      o_resp_data   = resp_data_q;
      o_resp_id     = cur_id;
    end
  end

endmodule
